// File: rtl/tc_io_hub.sv
// tc_io_hub: shares the TinyComp single-cycle I/O bus among four peripheral
// channels. Each channel has an output holding register and an input FIFO.
// Software sees back-pressure through InRdy and sticky OVF/UNF flags.
module tc_io_hub #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0100,
  parameter int unsigned IN_DEPTH  = 4
) (
  input  logic         Ph0,
  input  logic         Reset_n,
  input  logic [31:0]  IOaddr,
  input  logic [31:0]  OutData,
  input  logic         OutStrobe,
  input  logic         InStrobe,
  output logic [31:0]  InData,
  output logic         InRdy,
  output logic [3:0]   PoValid,
  input  logic [3:0]   PoReady,
  output logic [127:0] PoData,
  input  logic [3:0]   PiValid,
  output logic [3:0]   PiReady,
  input  logic [127:0] PiData
);

  localparam int unsigned PtrW = (IN_DEPTH > 1) ? $clog2(IN_DEPTH) : 1;
  localparam int unsigned CntW = PtrW + 1;

  logic [3:0]            po_valid_q, po_valid_d;
  logic [3:0][31:0]      po_data_q, po_data_d;
  logic [3:0][PtrW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [3:0][CntW-1:0]  cnt_q, cnt_d;
  logic [3:0]            ovf_q, ovf_d, unf_q, unf_d;
  logic                  rdy_en_q;
  logic [31:0]           mem_q [4][IN_DEPTH];

  logic                  hit;
  logic [1:0]            ch;
  logic                  sel_stat;
  logic [3:0]            not_full, non_empty, drain, accept, ovf_set;
  logic [3:0]            flush, discard, pop, unf_set, stat_rd, push;

  assign hit      = (IOaddr[31:3] == BASE_ADDR[31:3]);
  assign ch       = IOaddr[1:0];
  assign sel_stat = IOaddr[2];

  // PiReady is held low until the first edge after reset release.
  assign PiReady = {4{rdy_en_q}} & not_full;
  assign PoValid = po_valid_q;
  assign PoData  = po_data_q;

  // Per-channel event decode for this cycle.
  always_comb begin
    not_full  = '0;
    non_empty = '0;
    drain     = '0;
    accept    = '0;
    ovf_set   = '0;
    flush     = '0;
    discard   = '0;
    pop       = '0;
    unf_set   = '0;
    stat_rd   = '0;
    push      = '0;
    for (int c = 0; c < 4; c++) begin
      logic sel;
      sel          = hit && (ch == 2'(c));
      not_full[c]  = cnt_q[c] < CntW'(IN_DEPTH);
      non_empty[c] = cnt_q[c] != '0;
      drain[c]     = po_valid_q[c] & PoReady[c];
      // A write is taken when the register is empty or draining this same edge.
      accept[c]    = sel & OutStrobe & ~sel_stat & (~po_valid_q[c] | drain[c]);
      ovf_set[c]   = sel & OutStrobe & ~sel_stat & po_valid_q[c] & ~drain[c];
      flush[c]     = sel & OutStrobe & sel_stat & OutData[0];
      discard[c]   = sel & OutStrobe & sel_stat & OutData[1];
      pop[c]       = sel & InStrobe & ~sel_stat & non_empty[c];
      unf_set[c]   = sel & InStrobe & ~sel_stat & ~non_empty[c];
      stat_rd[c]   = sel & InStrobe & sel_stat;
      push[c]      = PiValid[c] & rdy_en_q & not_full[c];
    end
  end

  // Next-state for holding registers, FIFO pointers/counts and sticky flags.
  always_comb begin
    po_valid_d = po_valid_q;
    po_data_d  = po_data_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    cnt_d      = cnt_q;
    ovf_d      = ovf_q;
    unf_d      = unf_q;
    for (int c = 0; c < 4; c++) begin
      if (discard[c]) begin
        po_valid_d[c] = 1'b0;
      end else if (accept[c]) begin
        po_valid_d[c] = 1'b1;
      end else if (drain[c]) begin
        po_valid_d[c] = 1'b0;
      end
      if (accept[c]) begin
        po_data_d[c] = OutData;
      end
      if (flush[c]) begin
        wr_ptr_d[c] = '0;
        rd_ptr_d[c] = '0;
        cnt_d[c]    = '0;
      end else begin
        if (push[c]) wr_ptr_d[c] = wr_ptr_q[c] + PtrW'(1);
        if (pop[c])  rd_ptr_d[c] = rd_ptr_q[c] + PtrW'(1);
        cnt_d[c] = cnt_q[c] + CntW'(push[c]) - CntW'(pop[c]);
      end
      // Set wins over a same-edge status-read clear.
      ovf_d[c] = ovf_set[c] | (ovf_q[c] & ~stat_rd[c]);
      unf_d[c] = unf_set[c] | (unf_q[c] & ~stat_rd[c]);
    end
  end

  // Control state register with asynchronous reset.
  always_ff @(posedge Ph0 or negedge Reset_n) begin
    if (!Reset_n) begin
      po_valid_q <= '0;
      po_data_q  <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      ovf_q      <= '0;
      unf_q      <= '0;
      rdy_en_q   <= 1'b0;
    end else begin
      po_valid_q <= po_valid_d;
      po_data_q  <= po_data_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      ovf_q      <= ovf_d;
      unf_q      <= unf_d;
      rdy_en_q   <= 1'b1;
    end
  end

  // FIFO storage; contents are only meaningful under the count, so no reset.
  always_ff @(posedge Ph0) begin
    for (int c = 0; c < 4; c++) begin
      if (push[c]) mem_q[c][wr_ptr_q[c]] <= PiData[32*c +: 32];
    end
  end

  // Combinational read data and readiness for the addressed resource.
  always_comb begin
    InData = '0;
    InRdy  = 1'b0;
    if (hit) begin
      if (sel_stat) begin
        InData = {26'b0, unf_q[ch], ovf_q[ch], ~po_valid_q[ch], ~not_full[ch],
                  non_empty[ch], 1'b1};
        InRdy  = ~po_valid_q[ch] | PoReady[ch];
      end else begin
        InData = non_empty[ch] ? mem_q[ch][rd_ptr_q[ch]] : '0;
        InRdy  = non_empty[ch];
      end
    end
  end

endmodule

// File: tb/tb_tc_io_hub.sv
// Bench for tc_io_hub: a directed vector table, a reset-mid-stream sequence and
// a randomized run against a queue-based behavioural model.
module tb_tc_io_hub;

  localparam int unsigned D = 4;

  logic         Ph0 = 1'b0;
  logic         Reset_n;
  logic [31:0]  IOaddr, OutData;
  logic         OutStrobe, InStrobe;
  logic [31:0]  InData;
  logic         InRdy;
  logic [3:0]   PoValid, PoReady, PiValid, PiReady;
  logic [127:0] PoData, PiData;

  int checks = 0;
  int errors = 0;

  always #5 Ph0 = ~Ph0;

  tc_io_hub #(.BASE_ADDR(32'h0000_0100), .IN_DEPTH(D)) dut (
    .Ph0(Ph0), .Reset_n(Reset_n), .IOaddr(IOaddr), .OutData(OutData),
    .OutStrobe(OutStrobe), .InStrobe(InStrobe), .InData(InData), .InRdy(InRdy),
    .PoValid(PoValid), .PoReady(PoReady), .PoData(PoData),
    .PiValid(PiValid), .PiReady(PiReady), .PiData(PiData)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] od;
    logic        os;
    logic        is;
    logic [3:0]  por;
    logic [3:0]  piv;
    logic [31:0] pid;
    logic [31:0] e_data;
    logic        e_rdy;
    logic [3:0]  e_pov;
    logic [3:0]  e_pir;
    logic        chk_pod;
    logic [31:0] e_pod;
  } vec_t;

  vec_t tbl[$];

  // Behavioural model state.
  logic [31:0] mq[4][$];
  bit          mv[4];
  logic [31:0] md[4];
  bit          movf[4], munf[4];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge Ph0);
    #1;
  endtask

  task automatic idle();
    IOaddr = 32'h0; OutData = 32'h0; OutStrobe = 1'b0; InStrobe = 1'b0;
    PoReady = 4'h0; PiValid = 4'h0; PiData = '0;
  endtask

  task automatic add(input logic [31:0] addr, input logic [31:0] od, input logic os,
                     input logic is, input logic [3:0] por, input logic [3:0] piv,
                     input logic [31:0] pid, input logic [31:0] e_data, input logic e_rdy,
                     input logic [3:0] e_pov, input logic [3:0] e_pir, input logic chk_pod,
                     input logic [31:0] e_pod);
    vec_t v;
    v.addr = addr; v.od = od; v.os = os; v.is = is; v.por = por; v.piv = piv; v.pid = pid;
    v.e_data = e_data; v.e_rdy = e_rdy; v.e_pov = e_pov; v.e_pir = e_pir;
    v.chk_pod = chk_pod; v.e_pod = e_pod;
    tbl.push_back(v);
  endtask

  task automatic model_reset();
    for (int c = 0; c < 4; c++) begin
      mq[c].delete();
      mv[c] = 0; md[c] = '0; movf[c] = 0; munf[c] = 0;
    end
  endtask

  // Compare every DUT output against the model before the edge.
  task automatic model_check();
    bit          hit;
    int          ch;
    logic [31:0] exp_data;
    logic        exp_rdy;
    logic [3:0]  exp_pir, exp_pov;
    logic [127:0] exp_pod;
    bit          nonempty, full;
    hit = (IOaddr[31:3] == 29'h20);
    ch  = int'(IOaddr[1:0]);
    for (int c = 0; c < 4; c++) begin
      exp_pir[c] = (mq[c].size() < D);
      exp_pov[c] = mv[c];
      exp_pod[32*c +: 32] = md[c];
    end
    nonempty = (mq[ch].size() > 0);
    full     = (mq[ch].size() == D);
    exp_data = 32'h0;
    exp_rdy  = 1'b0;
    if (hit && IOaddr[2]) begin
      exp_data = {26'b0, munf[ch], movf[ch], !mv[ch], full, nonempty, 1'b1};
      exp_rdy  = !mv[ch] || PoReady[ch];
    end else if (hit) begin
      exp_data = nonempty ? mq[ch][0] : 32'h0;
      exp_rdy  = nonempty;
    end
    if (InStrobe || !hit) chk("rnd_indata", InData, exp_data);
    chk("rnd_inrdy", InRdy, exp_rdy);
    chk("rnd_povalid", PoValid, exp_pov);
    chk("rnd_piready", PiReady, exp_pir);
    chk("rnd_podata", PoData, exp_pod);
  endtask

  // Advance the model across one edge using the current inputs.
  task automatic model_edge();
    bit hit, st, sel, full_pre, drain, nv, fl, dc, oset, uset, clr;
    int ch;
    hit = (IOaddr[31:3] == 29'h20);
    ch  = int'(IOaddr[1:0]);
    st  = IOaddr[2];
    for (int c = 0; c < 4; c++) begin
      sel = hit && (ch == c);
      full_pre = (mq[c].size() >= D);
      drain = mv[c] && PoReady[c];
      nv = mv[c] && !drain;
      fl = 0; dc = 0; oset = 0; uset = 0; clr = 0;
      if (sel && OutStrobe && !st) begin
        if (!mv[c] || drain) begin nv = 1; md[c] = OutData; end
        else oset = 1;
      end
      if (sel && OutStrobe && st) begin fl = OutData[0]; dc = OutData[1]; end
      if (sel && InStrobe && st) clr = 1;
      if (sel && InStrobe && !st) begin
        if (mq[c].size() > 0) void'(mq[c].pop_front());
        else uset = 1;
      end
      if (PiValid[c] && !full_pre) mq[c].push_back(PiData[32*c +: 32]);
      if (fl) mq[c].delete();
      if (dc) nv = 0;
      mv[c] = nv;
      movf[c] = oset || (movf[c] && !clr);
      munf[c] = uset || (munf[c] && !clr);
    end
  endtask

  initial begin
    idle();
    Reset_n = 1'b0;
    #3;
    chk("rst_piready_low", PiReady, 4'h0);
    chk("rst_povalid", PoValid, 4'h0);
    step();
    step();
    Reset_n = 1'b1;
    step();

    // addr, od, os, is, por, piv, pid, e_data, e_rdy, e_pov, e_pir, chk_pod, e_pod
    add(32'h106, 32'h0, 0, 1, 4'h0, 4'h0, 32'h0, 32'h9, 1, 4'h0, 4'hF, 1, 32'h0);
    add(32'h000, 32'h5, 1, 1, 4'h0, 4'h0, 32'h0, 32'h0, 0, 4'h0, 4'hF, 0, 32'h0);
    add(32'h101, 32'hDEADBEEF, 1, 0, 4'h0, 4'h0, 32'h0, 32'h0, 0, 4'h0, 4'hF, 1, 32'h0);
    add(32'h101, 32'h1, 1, 0, 4'h0, 4'h0, 32'h0, 32'h0, 0, 4'h2, 4'hF, 1, 32'hDEADBEEF);
    add(32'h105, 32'h0, 0, 1, 4'h0, 4'h0, 32'h0, 32'h11, 0, 4'h2, 4'hF, 1, 32'hDEADBEEF);
    add(32'h105, 32'h0, 0, 1, 4'h0, 4'h0, 32'h0, 32'h01, 0, 4'h2, 4'hF, 1, 32'hDEADBEEF);
    add(32'h101, 32'h2, 1, 0, 4'h2, 4'h0, 32'h0, 32'h0, 0, 4'h2, 4'hF, 1, 32'hDEADBEEF);
    add(32'h105, 32'h0, 0, 1, 4'h0, 4'h0, 32'h0, 32'h01, 0, 4'h2, 4'hF, 1, 32'h2);
    add(32'h100, 32'h0, 0, 0, 4'h0, 4'h1, 32'h1, 32'h0, 0, 4'h2, 4'hF, 1, 32'h0);
    add(32'h100, 32'h0, 0, 0, 4'h0, 4'h1, 32'h2, 32'h0, 1, 4'h2, 4'hF, 0, 32'h0);
    add(32'h100, 32'h0, 0, 0, 4'h0, 4'h1, 32'h3, 32'h0, 1, 4'h2, 4'hF, 0, 32'h0);
    add(32'h100, 32'h0, 0, 0, 4'h0, 4'h1, 32'h4, 32'h0, 1, 4'h2, 4'hF, 0, 32'h0);
    add(32'h104, 32'h0, 0, 1, 4'h0, 4'h1, 32'h5, 32'hF, 1, 4'h2, 4'hE, 0, 32'h0);
    add(32'h100, 32'h0, 0, 1, 4'h0, 4'h0, 32'h0, 32'h1, 1, 4'h2, 4'hE, 0, 32'h0);
    add(32'h100, 32'h0, 0, 1, 4'h0, 4'h0, 32'h0, 32'h2, 1, 4'h2, 4'hF, 0, 32'h0);
    add(32'h100, 32'h0, 0, 1, 4'h0, 4'h1, 32'hA, 32'h3, 1, 4'h2, 4'hF, 0, 32'h0);
    add(32'h104, 32'h0, 0, 1, 4'h0, 4'h0, 32'h0, 32'hB, 1, 4'h2, 4'hF, 0, 32'h0);
    add(32'h100, 32'h0, 0, 1, 4'h0, 4'h0, 32'h0, 32'h4, 1, 4'h2, 4'hF, 0, 32'h0);
    add(32'h100, 32'h0, 0, 1, 4'h0, 4'h0, 32'h0, 32'hA, 1, 4'h2, 4'hF, 0, 32'h0);
    add(32'h100, 32'h0, 0, 1, 4'h0, 4'h0, 32'h0, 32'h0, 0, 4'h2, 4'hF, 0, 32'h0);
    add(32'h104, 32'h0, 0, 1, 4'h0, 4'h0, 32'h0, 32'h29, 1, 4'h2, 4'hF, 0, 32'h0);
    add(32'h104, 32'h0, 0, 1, 4'h0, 4'h0, 32'h0, 32'h09, 1, 4'h2, 4'hF, 0, 32'h0);
    add(32'h103, 32'h33, 1, 0, 4'h0, 4'h8, 32'h77, 32'h0, 0, 4'h2, 4'hF, 1, 32'h0);
    add(32'h107, 32'h0, 0, 1, 4'h0, 4'h8, 32'h78, 32'h03, 0, 4'hA, 4'hF, 1, 32'h33);
    add(32'h107, 32'h3, 1, 0, 4'h0, 4'h8, 32'h79, 32'h0, 0, 4'hA, 4'hF, 1, 32'h33);
    add(32'h107, 32'h0, 0, 1, 4'h0, 4'h0, 32'h0, 32'h09, 1, 4'h2, 4'hF, 0, 32'h0);
    add(32'h103, 32'h0, 0, 1, 4'h0, 4'h0, 32'h0, 32'h0, 0, 4'h2, 4'hF, 0, 32'h0);

    foreach (tbl[i]) begin
      IOaddr = tbl[i].addr; OutData = tbl[i].od;
      OutStrobe = tbl[i].os; InStrobe = tbl[i].is;
      PoReady = tbl[i].por; PiValid = tbl[i].piv; PiData = {4{tbl[i].pid}};
      #3;
      if (tbl[i].is) chk($sformatf("vec%0d_indata", i), InData, tbl[i].e_data);
      chk($sformatf("vec%0d_inrdy", i), InRdy, tbl[i].e_rdy);
      chk($sformatf("vec%0d_povalid", i), PoValid, tbl[i].e_pov);
      chk($sformatf("vec%0d_piready", i), PiReady, tbl[i].e_pir);
      if (tbl[i].chk_pod)
        chk($sformatf("vec%0d_podata", i), PoData[32*tbl[i].addr[1:0] +: 32], tbl[i].e_pod);
      step();
    end

    // Reset mid-stream: ch0 half full, ch2 holding a word.
    idle();
    IOaddr = 32'h102; OutData = 32'h55; OutStrobe = 1'b1;
    PiValid = 4'h1; PiData = {4{32'h11}};
    step();
    idle();
    PiValid = 4'h1; PiData = {4{32'h22}};
    step();
    idle();
    IOaddr = 32'h100;
    #1;
    chk("pre_rst_inrdy", InRdy, 1'b1);
    Reset_n = 1'b0;
    #1;
    chk("mid_rst_povalid", PoValid, 4'h0);
    chk("mid_rst_podata", PoData, 128'h0);
    chk("mid_rst_piready", PiReady, 4'h0);
    chk("mid_rst_inrdy", InRdy, 1'b0);
    chk("mid_rst_indata", InData, 32'h0);
    #1;
    Reset_n = 1'b1;
    step();
    IOaddr = 32'h104; InStrobe = 1'b1;
    #1;
    chk("post_rst_piready", PiReady, 4'hF);
    chk("post_rst_status", InData, 32'h9);
    step();
    idle();
    model_reset();

    // Randomized run against the behavioural model.
    for (int n = 0; n < 2000; n++) begin
      if ($urandom_range(0, 15) == 0) IOaddr = 32'h200 | 32'($urandom_range(0, 7));
      else IOaddr = 32'h100 + 32'($urandom_range(0, 7));
      OutData   = $urandom;
      OutStrobe = ($urandom_range(0, 3) == 0);
      InStrobe  = ($urandom_range(0, 3) == 0);
      for (int c = 0; c < 4; c++) begin
        PoReady[c] = ($urandom_range(0, 2) == 0);
        PiValid[c] = ($urandom_range(0, 1) == 0);
        PiData[32*c +: 32] = $urandom;
      end
      #3;
      model_check();
      model_edge();
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
